// File: rtl/wh_arith_pkg.sv
// rtl/wh_arith_pkg.sv - shared definitions for the wh arithmetic blocks
// Purpose: default operand width, FSM state encoding and counter width
//          shared by multiplier_wh and its step sub-module.
// Ports:   none (package)
package wh_arith_pkg;

  localparam int unsigned WH_WIDTH = 16;

  // Step counter only needs to reach WIDTH-1.
  localparam int unsigned WH_CNT_W = $clog2(WH_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wh_state_e;

endpackage

// File: rtl/mul_step_wh.sv
// rtl/mul_step_wh.sv - one conditional-add + right-shift multiply step
// Purpose: combinational shift-add step of the sequential multiplier.
//          The high half of the accumulator collects partial sums; the low
//          half holds the not-yet-consumed multiplier bits and fills with
//          product bits as they shift in from the top.
// Ports:
//   i_acc       in  2*WIDTH  current accumulator {acc_hi, acc_lo}
//   i_mcand     in  WIDTH    captured multiplicand
//   o_acc_next  out 2*WIDTH  accumulator after one step
module mul_step_wh
  import wh_arith_pkg::*;
#(
  parameter int WIDTH = WH_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [WIDTH:0] w_sum;

  // One extra bit keeps the carry of the add; it becomes the new MSB after
  // the shift, so nothing is lost even for all-ones operands plus addend.
  assign w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                    + (i_acc[0] ? {1'b0, i_mcand} : {(WIDTH+1){1'b0}});
  assign o_acc_next = {w_sum, i_acc[WIDTH-1:1]};

endmodule

// File: rtl/multiplier_wh.sv
// rtl/multiplier_wh.sv - sequential shift-add multiply-accumulate
// Purpose: product = multiplicand*multiplier + addend, one multiplier bit
//          per clock, start/busy/done handshake, constant WIDTH-cycle latency.
// Ports:
//   clk           in  1        system clock, rising edge
//   rst_n         in  1        asynchronous active-low reset
//   start         in  1        request; sampled only while idle
//   multiplicand  in  WIDTH    operand A (unsigned)
//   multiplier    in  WIDTH    operand B (unsigned)
//   addend        in  WIDTH    operand C (unsigned), added to A*B
//   busy          out 1        operation in progress
//   done          out 1        one-cycle pulse, product updated
//   product       out 2*WIDTH  A*B+C, held until the next completion
module multiplier_wh
  import wh_arith_pkg::*;
#(
  parameter int WIDTH = WH_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  wh_state_e          r_state;
  wh_state_e          w_state_next;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic               r_done;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_load;
  logic               w_last;

  mul_step_wh #(.WIDTH(WIDTH)) u_step (
    .i_acc      (r_acc),
    .i_mcand    (r_mcand),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (r_count == LAST_STEP) begin
          w_state_next = IDLE;
          w_last       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operands are captured on acceptance, so later input changes and
  // re-asserted start during RUN have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_load) begin
        r_mcand <= multiplicand;
        // Addend preloaded in the high half comes out as +C after WIDTH shifts.
        r_acc   <= {addend, multiplier};
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_acc   <= w_acc_next;
        r_count <= r_count + CW'(1);
      end
      r_done <= w_last;
      if (w_last) begin
        r_product <= w_acc_next;
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_multiplier_wh.sv
// tb/tb_multiplier_wh.sv - directed self-checking bench for multiplier_wh
module tb_multiplier_wh;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [15:0] addend;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int total_cnt;
  int bad_cnt;

  multiplier_wh #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    multiplicand = a;
    multiplier   = b;
    addend       = c;
  endtask

  // Single operation: start pulse, count edges after the accepting edge
  // until done, then check latency, result and busy release.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    set_ops(a, b, c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 16);
    chk({tag, "_product"}, product, exp);
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  logic [15:0] b2b_a [6];
  logic [15:0] b2b_b [6];
  logic [15:0] b2b_c [6];
  logic [31:0] b2b_p [6];

  initial begin
    int n;
    int last;
    int dones;
    logic [15:0] ra;
    logic [15:0] rb;
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    set_ops(16'd0, 16'd0, 16'd0);

    b2b_a = '{16'd7,  16'd10,  16'hFFFF,   16'd256,    16'd5, 16'd1};
    b2b_b = '{16'd3,  16'd10,  16'd2,      16'd256,    16'd0, 16'd1};
    b2b_c = '{16'd2,  16'd10,  16'd1,      16'd0,      16'd9, 16'd1};
    b2b_p = '{32'd23, 32'd110, 32'h1FFFF,  32'h10000,  32'd9, 32'd2};

    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'd7, 16'd3, 16'd2, 32'd23, "basic");
    do_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000, "all_ones");
    do_op(16'd142, 16'd7, 16'd6, 32'd1000, "round_trip");

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom_range(1, 65535));
      rb = 16'($urandom_range(1, 300));
      do_op(ra / rb, rb, ra % rb, {16'd0, ra}, "rt_sweep");
    end

    // Zero multiplicand with a re-pulsed start mid-run.
    @(negedge clk);
    set_ops(16'd0, 16'h1234, 16'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    dones = 0;
    last = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        set_ops(16'd99, 16'd99, 16'd99);
        start = 1'b1;
      end
      if (n == 6) start = 1'b0;
      if (done) begin
        dones++;
        if (last < 0) last = n;
      end
    end
    chk("zero_latency", last, 16);
    chk("zero_done_count", dones, 1);
    chk("zero_product", product, 5);

    // Reset in the middle of a run.
    @(negedge clk);
    set_ops(16'd100, 16'd200, 16'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    do_op(16'd3, 16'd4, 16'd0, 32'd12, "after_abort");

    // Back-to-back with start held high: operand k+1 stays on the bus until
    // the edge after done k accepts it.
    @(negedge clk);
    set_ops(b2b_a[0], b2b_b[0], b2b_c[0]);
    start = 1'b1;
    @(negedge clk);
    set_ops(b2b_a[1], b2b_b[1], b2b_c[1]);
    n = 0;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      while (!done && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_gap", n - last, (k == 0) ? 16 : 17);
      chk("b2b_product", product, b2b_p[k]);
      last = n;
      @(negedge clk);
      n++;
      if (k == 3) start = 1'b0;
      if (k < 4) set_ops(b2b_a[k+2], b2b_b[k+2], b2b_c[k+2]);
    end
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("b2b_drained", dones, 0);
    chk("b2b_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
